// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
// Holds the fetch FSM state encoding, the buffered-entry layout and a PC alignment helper.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are simply discarded.
  function automatic logic [INSTR_W-1:0] alignPc(input logic [INSTR_W-1:0] rawPc);
    return {rawPc[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, instruction} entries between instruction memory and decode.
// Supports push and pop in the same cycle, including when full; flush empties it in one cycle.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_pushEntry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t        r_mem [DEPTH];
  logic [AW-1:0]       r_rdPtr;
  logic [AW-1:0]       r_wrPtr;
  logic [CW-1:0]       r_count;
  logic                w_doPop;

  assign w_doPop = i_pop && (r_count != '0);

  // Storage is cleared on reset so the head reads as zero while the block is held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushEntry;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(w_doPop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, credit-limited imem requests, response buffering and redirect flush.
// Requests in flight at a redirect are counted as stale and their responses discarded.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  r_state;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_stale;

  logic [CW-1:0] w_fifoCount;
  logic          w_fifoValid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_pushEntry;
  logic [CW:0]   w_inFlight;
  logic          w_credit;
  logic          w_accept;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_outNext;
  logic [CW-1:0] w_staleAfterRsp;
  logic [31:0]   w_rspPc;

  // Credits come from registered occupancy only, so a pop this cycle frees room next cycle.
  assign w_inFlight = {1'b0, w_fifoCount} + {1'b0, r_outstanding};
  assign w_credit   = (w_inFlight < (CW+1)'(DEPTH));

  assign imem_req_valid = ~rst & (r_state == RUN) & w_credit;
  assign imem_req_addr  = r_pc;

  assign w_accept  = imem_req_valid & imem_req_ready;
  assign w_rsp     = imem_rsp_valid & (r_outstanding != '0);
  assign w_outNext = r_outstanding + CW'(w_accept) - CW'(w_rsp);

  assign w_staleAfterRsp = (w_rsp && (r_stale != '0)) ? (r_stale - CW'(1)) : r_stale;

  // In RUN every outstanding request was issued sequentially, so the oldest is pc - 4*outstanding.
  assign w_rspPc = r_pc - (32'(r_outstanding) << 2);

  assign w_push = w_rsp & (r_stale == '0) & (r_state == RUN) & ~redirect_valid;
  assign w_pop  = instr_valid & instr_ready & ~redirect_valid;

  assign w_pushEntry.pc    = w_rspPc;
  assign w_pushEntry.instr = imem_rsp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else begin
      r_outstanding <= w_outNext;
      if (redirect_valid) begin
        r_pc <= alignPc(redirect_pc);
        if (r_state == FLUSH) begin
          r_stale <= w_staleAfterRsp;
          r_state <= (w_staleAfterRsp != '0) ? FLUSH : RUN;
        end else begin
          // Everything still in flight after this edge, including a same-cycle accept, is stale.
          r_stale <= w_outNext;
          r_state <= (w_outNext != '0) ? FLUSH : RUN;
        end
      end else begin
        if (w_accept) begin
          r_pc <= r_pc + PC_STEP;
        end
        r_stale <= w_staleAfterRsp;
        if ((r_state == FLUSH) && (w_staleAfterRsp == '0)) begin
          r_state <= RUN;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushEntry(w_pushEntry),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_valid    (w_fifoValid),
    .o_head     (w_head),
    .o_count    (w_fifoCount)
  );

  assign instr_valid = w_fifoValid;
  assign instruction = w_head.instr;
  assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: an in-order memory model with variable latency and a
// stream-level reference (delivered PCs run sequentially from the last redirect target).
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } memEntry_t;

  typedef struct {
    bit          rdy;
    bit          reqRdy;
    bit          expReqValid;
    logic [31:0] expReqAddr;
    bit          expInstrValid;
    logic [31:0] expInstrPc;
  } vec_t;

  memEntry_t   memQ[$];
  vec_t        vecs[8];
  int          cycle;
  int          checks;
  int          errors;
  int          latency;
  int          popCount;
  int          reqCount;
  logic [31:0] expPc;
  logic [31:0] expReqPc;
  bit          holdPending;
  logic [31:0] holdAddr;
  bit          flushCheck;
  bit          sReqValid;
  logic [31:0] sReqAddr;
  bit          sInstrValid;
  logic [31:0] sInstrPc;
  bit          sPopFire;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    memQ.delete();
    expPc       = RESET_PC;
    expReqPc    = RESET_PC;
    holdPending = 1'b0;
    flushCheck  = 1'b0;
  endtask

  // Asserts reset mid-cycle, checks outputs asynchronously, releases away from the clock edge.
  task automatic applyReset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    modelReset();
    #1;
    checkOutput("rstReqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("rstReqAddr", imem_req_addr, RESET_PC);
    checkOutput("rstInstrValid", 32'(instr_valid), 32'd0);
    checkOutput("rstInstruction", instruction, 32'd0);
    checkOutput("rstInstrPc", instr_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock of stimulus: drives inputs, samples at negedge, checks against the stream model.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit rdy, input bit reqRdy);
    bit reqFire;
    bit rspFire;
    int staleCnt;
    int lat;
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    imem_req_ready = reqRdy;
    if (memQ.size() > 0 && memQ[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(memQ[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    sReqValid   = imem_req_valid;
    sReqAddr    = imem_req_addr;
    sInstrValid = instr_valid;
    sInstrPc    = instr_pc;
    sPopFire    = instr_valid & rdy;
    reqFire     = imem_req_valid & reqRdy;
    rspFire     = imem_rsp_valid;
    if (flushCheck) checkOutput("flushEmpty", 32'(instr_valid), 32'd0);
    if (holdPending) begin
      checkOutput("holdValid", 32'(imem_req_valid), 32'd1);
      checkOutput("holdAddr", imem_req_addr, holdAddr);
    end
    if (imem_req_valid) begin
      checkOutput("reqAddr", imem_req_addr, expReqPc);
      staleCnt = 0;
      foreach (memQ[i]) if (memQ[i].stale) staleCnt++;
      checkOutput("reqWhileStale", 32'(staleCnt), 32'd0);
    end
    if (sPopFire && !redir) begin
      checkOutput("popPc", instr_pc, expPc);
      checkOutput("popInstr", instruction, memWord(expPc));
      expPc = expPc + 32'd4;
      popCount++;
    end
    checkOutput("inFlightBound", 32'(memQ.size() <= DEPTH), 32'd1);
    holdPending = imem_req_valid & ~reqRdy & ~redir;
    holdAddr    = imem_req_addr;
    flushCheck  = redir;
    @(posedge clk);
    cycle++;
    if (reqFire) begin
      lat = (latency > 0) ? latency : int'($urandom_range(1, 4));
      memQ.push_back('{sReqAddr, cycle + lat - 1, 1'b0});
      reqCount++;
      expReqPc = expReqPc + 32'd4;
    end
    if (rspFire) void'(memQ.pop_front());
    if (redir) begin
      foreach (memQ[i]) memQ[i].stale = 1'b1;
      expPc    = rpc & ~32'd3;
      expReqPc = rpc & ~32'd3;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          startReq;
    int          startPop;
    bit          found;
    int          got;
    logic [31:0] heldAddr;
    logic [31:0] wrapPcs[3];
    logic [31:0] expWrap[3];

    checks = 0; errors = 0; cycle = 0; popCount = 0; reqCount = 0; latency = 1;
    rst = 1'b1; instr_ready = 1'b0; imem_req_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    modelReset();

    // Steady-state fill with a 1-cycle memory, per-cycle expectations from the credit rule.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};

    @(posedge clk); #1;
    applyReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'h0, vecs[i].rdy, vecs[i].reqRdy);
      checkOutput($sformatf("t1ReqValid%0d", i), 32'(sReqValid), 32'(vecs[i].expReqValid));
      if (vecs[i].expReqValid) checkOutput($sformatf("t1ReqAddr%0d", i), sReqAddr, vecs[i].expReqAddr);
      checkOutput($sformatf("t1InstrValid%0d", i), 32'(sInstrValid), 32'(vecs[i].expInstrValid));
      if (vecs[i].expInstrValid) checkOutput($sformatf("t1InstrPc%0d", i), sInstrPc, vecs[i].expInstrPc);
    end

    // Decode stalled: only DEPTH requests may be issued.
    applyReset();
    startReq = reqCount;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t2ReqCount", 32'(reqCount - startReq), 32'(DEPTH));
    checkOutput("t2ReqValidLow", 32'(sReqValid), 32'd0);
    startPop = popCount;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t2Drained", 32'(popCount - startPop >= 2), 32'd1);

    // Memory back-pressure: request must hold.
    heldAddr = '0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      if (i == 3) heldAddr = sReqAddr;
      if (i >= 3) checkOutput($sformatf("t3Valid%0d", i), 32'(sReqValid), 32'd1);
      if (i > 3) checkOutput($sformatf("t3Addr%0d", i), sReqAddr, heldAddr);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with two slow requests in flight.
    latency = 3;
    applyReset();
    for (int i = 0; i < 10 && memQ.size() < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t4Outstanding", 32'(memQ.size()), 32'd2);
    applyStimulus(1'b1, 32'h0000_1002, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      if (sPopFire) begin
        found = 1'b1;
        checkOutput("t4FirstPc", sInstrPc, 32'h0000_1000);
      end
    end
    checkOutput("t4Delivered", 32'(found), 32'd1);

    // Redirect coinciding with a response and a pop.
    latency = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid && memQ.size() > 0 && memQ[0].due <= cycle) begin
        found = 1'b1;
        applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b1);
      end else begin
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      end
    end
    checkOutput("t5Coincide", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      if (sPopFire) begin
        found = 1'b1;
        checkOutput("t5FirstPc", sInstrPc, 32'h0000_2000);
      end
    end
    checkOutput("t5Delivered", 32'(found), 32'd1);

    // Address wrap, then asynchronous reset mid-stream.
    expWrap[0] = 32'hFFFF_FFF8; expWrap[1] = 32'hFFFF_FFFC; expWrap[2] = 32'h0000_0000;
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    got = 0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      if (sPopFire) begin
        wrapPcs[got] = sInstrPc;
        got++;
      end
    end
    checkOutput("t6WrapCount", 32'(got), 32'd3);
    for (int i = 0; i < got; i++) checkOutput($sformatf("t6WrapPc%0d", i), wrapPcs[i], expWrap[i]);
    #2;
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    checkOutput("t6RstReqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("t6RstReqAddr", imem_req_addr, RESET_PC);
    checkOutput("t6RstInstrValid", 32'(instr_valid), 32'd0);
    checkOutput("t6RstInstruction", instruction, 32'd0);
    checkOutput("t6RstInstrPc", instr_pc, 32'd0);
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      if (sReqValid) begin
        found = 1'b1;
        checkOutput("t6Refetch", sReqAddr, RESET_PC);
      end
    end
    checkOutput("t6RefetchSeen", 32'(found), 32'd1);

    // Randomised traffic against the stream model.
    latency = 0;
    applyReset();
    startPop = popCount;
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) < 4, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    checkOutput("randProgress", 32'(popCount - startPop > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
